// File: rtl/ne_decoder_pkg.sv
// ne_decoder_pkg: shared decoder geometry constants and the HD unloader state encoding.
package ne_decoder_pkg;
  localparam int Kb           = 14;
  localparam int HDWIDTH      = 32;
  localparam int NLINES       = 16;
  localparam int ADDRESSWIDTH = 5;
  localparam int KW           = $clog2(Kb);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, SEND, DONE, REARM} hd_unload_state_t;
endpackage

// File: rtl/ne_hd_word_mux.sv
// ne_hd_word_mux: registered Kb-to-1 word selector; loads word i_k of i_vec when i_ld.
module ne_hd_word_mux
  import ne_decoder_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_ld,
  input  logic [Kb*HDWIDTH-1:0] i_vec,
  input  logic [KW-1:0]         i_k,
  output logic [HDWIDTH-1:0]    o_word
);
  logic [HDWIDTH-1:0] r_word;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_word <= '0;
    else if (i_ld) r_word <= i_vec[i_k*HDWIDTH +: HDWIDTH];
  assign o_word = r_word;
endmodule

// File: rtl/ne_hd_unloader.sv
// ne_hd_unloader: walks the Lmem HD unload port and streams each line as HDWIDTH-bit words.
// NE_HD_UNLOAD_PREFETCH_EN adds a shadow line buffer so consecutive lines stream without gaps.
module ne_hd_unloader
  import ne_decoder_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    decoder_ready,
  output logic                    unload_en,
  output logic [ADDRESSWIDTH-1:0] unloadAddress,
  input  logic [Kb*HDWIDTH-1:0]   unload_HDout_vec_regout,
  output logic [HDWIDTH-1:0]      hd_data,
  output logic                    hd_valid,
  input  logic                    hd_ready,
  output logic                    hd_last,
  output logic                    busy,
  output logic                    done
);
  hd_unload_state_t        r_state, w_nxt;
  logic [ADDRESSWIDTH-1:0] r_line, w_line, r_addr;
  logic [KW-1:0]           r_k, w_k;
  logic [Kb*HDWIDTH-1:0]   r_buf, w_vec;
  logic [RD_LAT-1:0]       r_pipe;
  logic r_en, r_valid, r_last, r_busy, r_done;
  logic w_ld, w_new, w_pf, w_cap, w_hs, w_endl, w_endf;
`ifdef NE_HD_UNLOAD_PREFETCH_EN
  logic [Kb*HDWIDTH-1:0]   r_sh;
  logic                    r_sh_vld;
`endif
  // r_pipe tracks the in-flight read so capture lands exactly RD_LAT cycles after unload_en
  assign w_cap  = r_pipe[RD_LAT-1];
  assign w_hs   = r_valid & hd_ready;
  assign w_endl = w_hs && r_k == KW'(Kb-1);
  assign w_endf = r_line == ADDRESSWIDTH'(NLINES-1);
  always_comb begin
    w_nxt  = r_state;
    w_ld   = 1'b0;
    w_new  = 1'b0;
    w_vec  = r_buf;
    w_k    = r_k;
    w_line = r_line;
    case (r_state)
      IDLE: if (decoder_ready) begin
        w_nxt  = REQ;
        w_line = '0;
      end
      REQ: w_nxt = WAIT;
`ifdef NE_HD_UNLOAD_PREFETCH_EN
      WAIT: if (w_cap || r_sh_vld) begin
        w_nxt = SEND;
        w_ld  = 1'b1;
        w_new = 1'b1;
        w_vec = r_sh_vld ? r_sh : unload_HDout_vec_regout;
        w_k   = '0;
      end
      SEND: if (w_endl && w_endf) w_nxt = DONE;
      else if (w_endl) begin
        w_line = r_line + 1'b1;
        w_nxt  = r_sh_vld ? SEND : WAIT;
        w_ld   = r_sh_vld;
        w_new  = r_sh_vld;
        w_vec  = r_sh;
        w_k    = '0;
      end else if (w_hs) begin
        w_ld = 1'b1;
        w_k  = r_k + 1'b1;
      end
`else
      WAIT: if (w_cap) begin
        w_nxt = SEND;
        w_ld  = 1'b1;
        w_new = 1'b1;
        w_vec = unload_HDout_vec_regout;
        w_k   = '0;
      end
      SEND: if (w_endl) begin
        w_nxt  = w_endf ? DONE : REQ;
        w_line = w_endf ? r_line : r_line + 1'b1;
      end else if (w_hs) begin
        w_ld = 1'b1;
        w_k  = r_k + 1'b1;
      end
`endif
      DONE: w_nxt = REARM;
      REARM: if (!decoder_ready) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end
`ifdef NE_HD_UNLOAD_PREFETCH_EN
  assign w_pf = w_new && w_line != ADDRESSWIDTH'(NLINES-1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_sh     <= '0;
      r_sh_vld <= 1'b0;
    end else if (w_cap && r_state == SEND) begin
      r_sh     <= unload_HDout_vec_regout;
      r_sh_vld <= 1'b1;
    end else if (w_new) r_sh_vld <= 1'b0;
`else
  assign w_pf = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_line  <= '0;
      r_k     <= '0;
      r_buf   <= '0;
      r_pipe  <= '0;
      r_en    <= 1'b0;
      r_addr  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_line  <= w_line;
      r_k     <= w_k;
      if (w_new) r_buf <= w_vec;
      r_pipe  <= (r_pipe << 1) | RD_LAT'(r_en);
      r_en    <= w_nxt == REQ || w_pf;
      r_addr  <= w_nxt == REQ ? w_line : w_pf ? w_line + 1'b1 : '0;
      r_valid <= w_nxt == SEND;
      r_last  <= w_nxt == SEND && w_line == ADDRESSWIDTH'(NLINES-1) && w_k == KW'(Kb-1);
      r_busy  <= w_nxt inside {REQ, WAIT, SEND, DONE};
      r_done  <= w_nxt == DONE;
    end
  ne_hd_word_mux u_mux (
    .clk    (clk),
    .rst    (rst),
    .i_ld   (w_ld),
    .i_vec  (w_vec),
    .i_k    (w_k),
    .o_word (hd_data)
  );
  assign unload_en     = r_en;
  assign unloadAddress = r_addr;
  assign hd_valid      = r_valid;
  assign hd_last       = r_last;
  assign busy          = r_busy;
  assign done          = r_done;
endmodule
